pipe_skid_reg: RTL and testbench

//  Elastic pipeline register: the consuming end of a registered D->Q stage.

---
 rtl/pipe_pkg.sv | 10 +
 rtl/pipe_skid_reg.sv | 96 +++++++++
 tb/tb_pipe_skid_reg.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// State encoding for elastic pipeline registers, shared by later stages and benches.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline register with a skid entry so IN_READY comes straight from a flop.
// OUT_DATA is always the main entry; the skid entry only catches the word that arrives while main stalls.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned n = 32
) (
    input  logic         CLOCK,
    input  logic         RESET,
    input  logic         FLUSH,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [n-1:0] IN_DATA,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [n-1:0] OUT_DATA,
    output logic [1:0]   COUNT
);

    pipe_state_t  state, next_state;
    logic [n-1:0] main_q, skid_q;
    logic         ready_q;
    logic         in_fire, out_fire;
    logic         ld_main, main_from_skid, ld_skid;

    assign in_fire  = IN_VALID & ready_q;
    assign out_fire = (state != EMPTY) & OUT_READY;

    always_comb begin
        next_state     = state;
        ld_main        = 1'b0;
        main_from_skid = 1'b0;
        ld_skid        = 1'b0;
        if (FLUSH) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        next_state = BUSY;
                        ld_main    = 1'b1;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        ld_main = 1'b1;
                    end else if (in_fire) begin
                        next_state = FULL;
                        ld_skid    = 1'b1;
                    end else if (out_fire) begin
                        next_state = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        next_state     = BUSY;
                        ld_main        = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: next_state = EMPTY;
            endcase
        end
    end

    // Data registers load only on a handshake, so X on an idle IN_DATA never reaches state.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state   <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state   <= next_state;
            ready_q <= (next_state != FULL);
            if (ld_main)
                main_q <= main_from_skid ? skid_q : IN_DATA;
            if (ld_skid)
                skid_q <= IN_DATA;
        end
    end

    always_comb begin
        case (state)
            EMPTY:   COUNT = 2'd0;
            BUSY:    COUNT = 2'd1;
            FULL:    COUNT = 2'd2;
            default: COUNT = 2'd0;
        endcase
    end

    assign OUT_VALID = (state != EMPTY);
    assign OUT_DATA  = main_q;
    assign IN_READY  = ready_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: vector table per clock plus reset/async-reset sequences.
module tb_pipe_skid_reg;
    import pipe_pkg::*;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        FLUSH;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] IN_DATA;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] OUT_DATA;
    logic [1:0]  COUNT;

    int checks = 0;
    int errors = 0;

    pipe_skid_reg #(.n(32)) dut (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .FLUSH    (FLUSH),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .IN_DATA  (IN_DATA),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .OUT_DATA (OUT_DATA),
        .COUNT    (COUNT)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        fl;
        logic        ov;
        logic [31:0] od;
        logic        chk_od;
        logic [1:0]  cnt;
        logic        ir;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic iv, logic [31:0] d, logic ordy, logic fl,
                                logic ov, logic [31:0] od, logic chk_od,
                                logic [1:0] cnt, logic ir);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
        v.ov = ov; v.od = od; v.chk_od = chk_od; v.cnt = cnt; v.ir = ir;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    initial begin
        logic [31:0] xword;
        xword = 'x;

        // Single pass
        vecs.push_back(mk(1, 32'h8000, 1, 0, 1, 32'h8000, 1, 1, 1));
        vecs.push_back(mk(0, 32'h0,    1, 0, 0, 32'h8000, 1, 0, 1));
        // Streaming 1..8
        for (int unsigned i = 1; i <= 8; i++)
            vecs.push_back(mk(1, i, 1, 0, 1, i, 1, 1, 1));
        vecs.push_back(mk(0, 32'h0, 1, 0, 0, 32'h8, 1, 0, 1));
        // Backpressure
        vecs.push_back(mk(1, 32'hA, 0, 0, 1, 32'hA, 1, 1, 1));
        vecs.push_back(mk(1, 32'hB, 0, 0, 1, 32'hA, 1, 2, 0));
        vecs.push_back(mk(1, 32'hD, 0, 0, 1, 32'hA, 1, 2, 0));
        vecs.push_back(mk(0, 32'h0, 1, 0, 1, 32'hB, 1, 1, 1));
        vecs.push_back(mk(0, 32'h0, 1, 0, 0, 32'hB, 1, 0, 1));
        // Flush from FULL with a word offered
        vecs.push_back(mk(1, 32'hA, 0, 0, 1, 32'hA, 1, 1, 1));
        vecs.push_back(mk(1, 32'hB, 0, 0, 1, 32'hA, 1, 2, 0));
        vecs.push_back(mk(1, 32'hC, 0, 1, 0, 32'h0, 0, 0, 1));
        vecs.push_back(mk(0, 32'h0, 1, 0, 0, 32'h0, 0, 0, 1));
        // Flush from BUSY while a handshake happens in the same cycle
        vecs.push_back(mk(1, 32'hE, 0, 0, 1, 32'hE, 1, 1, 1));
        vecs.push_back(mk(1, 32'hF, 1, 1, 0, 32'h0, 0, 0, 1));
        vecs.push_back(mk(0, 32'h0, 1, 0, 0, 32'h0, 0, 0, 1));
        // Recovery, then idle X on IN_DATA must not disturb the held word
        vecs.push_back(mk(1, 32'h1234, 1, 0, 1, 32'h1234, 1, 1, 1));
        vecs.push_back(mk(0, xword,    0, 0, 1, 32'h1234, 1, 1, 1));

        RESET = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b0; IN_DATA = '0; OUT_READY = 1'b0;

        repeat (2) step();
        chk("rst.ov",  {31'b0, OUT_VALID}, 32'd0);
        chk("rst.cnt", {30'b0, COUNT},     32'd0);
        chk("rst.ir",  {31'b0, IN_READY},  32'd0);
        chk("rst.od",  OUT_DATA,           32'd0);

        @(negedge CLOCK);
        RESET = 1'b1;
        step();
        chk("rel.ir", {31'b0, IN_READY},  32'd1);
        chk("rel.ov", {31'b0, OUT_VALID}, 32'd0);

        foreach (vecs[i]) begin
            @(negedge CLOCK);
            IN_VALID  = vecs[i].iv;
            IN_DATA   = vecs[i].d;
            OUT_READY = vecs[i].ordy;
            FLUSH     = vecs[i].fl;
            step();
            chk($sformatf("v%0d.ov", i),  {31'b0, OUT_VALID}, {31'b0, vecs[i].ov});
            chk($sformatf("v%0d.cnt", i), {30'b0, COUNT},     {30'b0, vecs[i].cnt});
            chk($sformatf("v%0d.ir", i),  {31'b0, IN_READY},  {31'b0, vecs[i].ir});
            if (vecs[i].chk_od)
                chk($sformatf("v%0d.od", i), OUT_DATA, vecs[i].od);
            if (vecs[i].fl || (i > 0 && vecs[i-1].fl)) begin
                checks++;
                if (OUT_DATA === 32'hC && OUT_VALID) begin
                    errors++;
                    $display("FAIL v%0d.flushed_word: got %h valid, required dropped", i, OUT_DATA);
                end
            end
        end

        // Async reset mid-stream while FULL
        @(negedge CLOCK);
        FLUSH = 1'b0; OUT_READY = 1'b0; IN_VALID = 1'b1; IN_DATA = 32'hA1;
        step();
        @(negedge CLOCK);
        IN_DATA = 32'hA2;
        step();
        chk("ar.pre_cnt", {30'b0, COUNT}, 32'd2);
        #2;
        RESET = 1'b0;
        #1;
        chk("ar.ov",  {31'b0, OUT_VALID}, 32'd0);
        chk("ar.cnt", {30'b0, COUNT},     32'd0);
        chk("ar.ir",  {31'b0, IN_READY},  32'd0);
        chk("ar.od",  OUT_DATA,           32'd0);
        @(negedge CLOCK);
        IN_VALID = 1'b0;
        RESET = 1'b1;
        step();
        chk("ar.rel_ir",  {31'b0, IN_READY}, 32'd1);
        chk("ar.rel_cnt", {30'b0, COUNT},    32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
